// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: fetches the word at the PC over a req/ack
// memory handshake and hands it to IF/ID, pausing the PC until delivery.
module if_fetch_ctrl #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Pc_In,
  input  logic              Redirect_In,
  input  logic              Id_Stall_In,
  output logic              Mem_Req_Out,
  output logic [ADDR_W-1:0] Mem_Addr_Out,
  input  logic              Mem_Ack_In,
  input  logic [31:0]       Mem_Rdata_In,
  output logic [31:0]       Instr_Out,
  output logic [31:0]       Instr_Pc_Out,
  output logic              Instr_Valid_Out,
  output logic              Pause_Out
);

  typedef enum logic [1:0] {IDLE, BUSY, DROP, PEND} state_e;

  state_e            state_q, state_d;
  logic              memReq_q, memReq_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [31:0]       pcWord_q, pcWord_d;
  logic [31:0]       skid_q, skid_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       instrPc_q, instrPc_d;
  logic              valid_q, valid_d;
  logic              deliver;
  logic [31:0]       deliverData;
  logic [31:0]       deliverPc;

  assign deliverPc = (pcWord_q << 2) + BASE_ADDR;

  always_comb begin
    state_d     = state_q;
    memReq_d    = memReq_q;
    memAddr_d   = memAddr_q;
    pcWord_d    = pcWord_q;
    skid_d      = skid_q;
    instr_d     = instr_q;
    instrPc_d   = instrPc_q;
    valid_d     = valid_q;
    deliver     = 1'b0;
    deliverData = skid_q;

    case (state_q)
      IDLE: begin
        if (!Id_Stall_In && !Redirect_In) begin
          memAddr_d = Pc_In[ADDR_W-1:0];
          pcWord_d  = Pc_In;
          memReq_d  = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // A redirect makes the outstanding fetch wrong-path; the request still
        // has to complete, so DROP swallows its eventual ack.
        if (Redirect_In) begin
          if (Mem_Ack_In) begin
            memReq_d = 1'b0;
            state_d  = IDLE;
          end else begin
            state_d = DROP;
          end
        end else if (Mem_Ack_In) begin
          memReq_d = 1'b0;
          if (!Id_Stall_In) begin
            deliver     = 1'b1;
            deliverData = Mem_Rdata_In;
            state_d     = IDLE;
          end else begin
            skid_d  = Mem_Rdata_In;
            state_d = PEND;
          end
        end
      end
      DROP: begin
        if (Mem_Ack_In) begin
          memReq_d = 1'b0;
          state_d  = IDLE;
        end
      end
      PEND: begin
        if (Redirect_In) begin
          state_d = IDLE;
        end else if (!Id_Stall_In) begin
          deliver = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Decode consumes the held instruction on any unstalled edge.
    if (deliver) begin
      instr_d   = deliverData;
      instrPc_d = deliverPc;
      valid_d   = 1'b1;
    end else if (!Id_Stall_In) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      memReq_q  <= 1'b0;
      memAddr_q <= '0;
      pcWord_q  <= '0;
      skid_q    <= '0;
      instr_q   <= '0;
      instrPc_q <= BASE_ADDR;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      memReq_q  <= memReq_d;
      memAddr_q <= memAddr_d;
      pcWord_q  <= pcWord_d;
      skid_q    <= skid_d;
      instr_q   <= instr_d;
      instrPc_q <= instrPc_d;
      valid_q   <= valid_d;
    end
  end

  // The PC may advance only on the edge that hands an instruction to decode.
  assign Pause_Out = Reset ||
                     !(((state_q == BUSY) && Mem_Ack_In && !Id_Stall_In && !Redirect_In) ||
                       ((state_q == PEND) && !Id_Stall_In && !Redirect_In));

  assign Mem_Req_Out     = memReq_q;
  assign Mem_Addr_Out    = memAddr_q;
  assign Instr_Out       = instr_q;
  assign Instr_Pc_Out    = instrPc_q;
  assign Instr_Valid_Out = valid_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench for if_fetch_ctrl against a transaction-level model of
// the outstanding fetch, the held-back instruction and the IF/ID output.
module tb_if_fetch_ctrl;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pcIn;
  logic        redirect;
  logic        stall;
  logic        memReq;
  logic [11:0] memAddr;
  logic        memAck;
  logic [31:0] memRdata;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrValid;
  logic        pause;

  int testsRun  = 0;
  int failCount = 0;

  // Model: one in-flight fetch (maybe wrong-path), one parked instruction,
  // and the instruction currently presented to decode.
  bit          fetchOpen;
  bit          fetchWrong;
  logic [31:0] fetchWord;
  logic [11:0] lastAddr;
  bit          parkedFull;
  logic [31:0] parkedData;
  logic [31:0] outInstr;
  logic [31:0] outPc;
  bit          outValid;

  always #5 clock = ~clock;

  if_fetch_ctrl dut (
    .Clk(clock), .Reset(reset), .Pc_In(pcIn), .Redirect_In(redirect),
    .Id_Stall_In(stall), .Mem_Req_Out(memReq), .Mem_Addr_Out(memAddr),
    .Mem_Ack_In(memAck), .Mem_Rdata_In(memRdata), .Instr_Out(instr),
    .Instr_Pc_Out(instrPc), .Instr_Valid_Out(instrValid), .Pause_Out(pause)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit modelPause();
    if (reset) return 1'b1;
    if (fetchOpen && !fetchWrong && memAck && !stall && !redirect) return 1'b0;
    if (!fetchOpen && parkedFull && !stall && !redirect) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelEdge();
    bit delivered = 1'b0;
    if (reset) begin
      fetchOpen = 0; fetchWrong = 0; fetchWord = '0; lastAddr = '0;
      parkedFull = 0; parkedData = '0;
      outInstr = '0; outPc = BASE; outValid = 0;
      return;
    end
    if (fetchOpen) begin
      if (memAck) begin
        fetchOpen = 0;
        if (!fetchWrong && !redirect) begin
          if (!stall) begin
            outInstr = memRdata; outPc = fetchWord * 4 + BASE; delivered = 1;
          end else begin
            parkedFull = 1; parkedData = memRdata;
          end
        end
      end else if (redirect) begin
        fetchWrong = 1;
      end
    end else if (parkedFull) begin
      if (redirect) parkedFull = 0;
      else if (!stall) begin
        outInstr = parkedData; outPc = fetchWord * 4 + BASE; delivered = 1;
        parkedFull = 0;
      end
    end else if (!stall && !redirect) begin
      fetchOpen = 1; fetchWrong = 0; fetchWord = pcIn; lastAddr = pcIn[11:0];
    end
    if (delivered) outValid = 1;
    else if (!stall) outValid = 0;
  endtask

  // Called just after a rising edge: drive inputs, check the combinational
  // pause mid-cycle, advance the model at the edge, then check registers.
  task automatic applyStimulus(input bit r, input logic [31:0] pc, input bit rd,
                               input bit st, input bit ak, input logic [31:0] data);
    reset = r; pcIn = pc; redirect = rd; stall = st; memAck = ak; memRdata = data;
    @(negedge clock);
    checkOutput("pause", {31'b0, pause}, {31'b0, modelPause()});
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput("req",   {31'b0, memReq},     {31'b0, fetchOpen});
    checkOutput("addr",  {20'b0, memAddr},    {20'b0, lastAddr});
    checkOutput("instr", instr,               outInstr);
    checkOutput("pc",    instrPc,             outPc);
    checkOutput("valid", {31'b0, instrValid}, {31'b0, outValid});
  endtask

  initial begin
    reset = 1; pcIn = '0; redirect = 0; stall = 0; memAck = 0; memRdata = '0;
    @(posedge clock); #1;
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Zero-wait fetch of word 0, then a stalled fetch of word 5 that parks.
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h3C01_1234);
    checkOutput("firstInstr", instr, 32'h3C01_1234);
    checkOutput("firstPc", instrPc, 32'h0000_3000);
    applyStimulus(0, 5, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 9, 0, 0, 0, 0);
    applyStimulus(0, 9, 0, 1, 1, 32'h1111_2222);
    applyStimulus(0, 9, 0, 1, 0, 0);
    applyStimulus(0, 9, 0, 0, 0, 0);
    checkOutput("parkedPc", instrPc, 32'h0000_3014);

    // Redirect while busy: the late DEADBEEF must never reach decode.
    applyStimulus(0, 7, 0, 0, 0, 0);
    applyStimulus(0, 7, 1, 0, 0, 0);
    applyStimulus(0, 7, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("dropData", {31'b0, instr == 32'hDEAD_BEEF}, 32'd0);

    // Reset in the middle of a fetch, followed by a late ack.
    applyStimulus(0, 3, 0, 0, 0, 0);
    applyStimulus(1, 3, 0, 0, 0, 0);
    applyStimulus(0, 3, 0, 1, 1, 32'h5555_AAAA);

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 8191);
      applyStimulus($urandom_range(0, 99) == 0, pc,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1, $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller on the consumer side of the PC register. It takes the PC word index and fetches the instruction over a req/ack instruction-memory handshake. It delivers the instruction, with its byte PC, to the IF/ID boundary. It drives Pause back to the PC so the PC advances only at the edge where an instruction is delivered to decode.

Parameters:
ADDR_W, 12, width of the instruction-memory word address (Mem_Addr_Out = Pc_In[ADDR_W-1:0]).
BASE_ADDR, 32'h0000_3000, byte address of word index 0; Instr_Pc_Out = (pc_word << 2) + BASE_ADDR.

Ports:
Clk  in  1  clock; all state updates on rising edge.
Reset  in  1  synchronous reset, active-high.
Pc_In  in  32  current PC word index from the PC register.
Redirect_In  in  1  high in the cycle the PC loads a jump/branch target (Jump_In | Pc_Src_In).
Id_Stall_In  in  1  decode stage cannot accept a new instruction this cycle.
Mem_Req_Out  out  1  fetch request to instruction memory (registered).
Mem_Addr_Out  out  ADDR_W  word address of the outstanding request (registered).
Mem_Ack_In  in  1  memory response strobe; Mem_Rdata_In is valid in the same cycle.
Mem_Rdata_In  in  32  instruction word.
Instr_Out  out  32  instruction delivered to IF/ID.
Instr_Pc_Out  out  32  byte PC of Instr_Out.
Instr_Valid_Out  out  1  Instr_Out holds a new, not-yet-consumed instruction.
Pause_Out  out  1  to PC Pause input; combinational.

Behaviour:
- Reset (synchronous, active-high, Clk) has priority over everything, including mid-fetch and PEND.
  - state=IDLE, Mem_Req_Out=0, Mem_Addr_Out=0, Instr_Out=0, Instr_Pc_Out=BASE_ADDR, Instr_Valid_Out=0, skid buffer cleared.
- States: IDLE, BUSY, DROP, PEND.
- IDLE:
  - Mem_Req_Out=0.
  - If !Id_Stall_In and !Redirect_In: latch Mem_Addr_Out<=Pc_In[ADDR_W-1:0], latch pc_word<=Pc_In, Mem_Req_Out<=1, go BUSY.
  - Otherwise stay in IDLE.
- BUSY: Mem_Req_Out and Mem_Addr_Out are held stable until Mem_Ack_In is sampled high. The request is never withdrawn.
  - Redirect_In=1 (with or without ack): the fetch is wrong-path.
    - If ack is in the same cycle: drop Req, go IDLE.
    - Otherwise: go DROP.
    - No delivery in either case.
  - Ack, !Id_Stall_In: Instr_Out<=Mem_Rdata_In, Instr_Pc_Out<=(pc_word<<2)+BASE_ADDR, Instr_Valid_Out<=1, Req<=0, go IDLE.
  - Ack, Id_Stall_In: capture data into the skid register, Req<=0, go PEND.
  - No ack: stay in BUSY.
- DROP:
  - Req held until Ack. On Ack, discard data, Req<=0, go IDLE. Redirect_In is ignored.
- PEND:
  - Redirect_In=1: discard skid, go IDLE.
  - Else if !Id_Stall_In: deliver skid to Instr_Out/Instr_Pc_Out, Instr_Valid_Out<=1, go IDLE.
- Instr_Valid_Out:
  - Cleared at any edge where Id_Stall_In=0 and no delivery occurs (decode consumed it).
  - Held while Id_Stall_In=1.
  - Instr_Out and Instr_Pc_Out hold their value when there is no delivery.
- Pause_Out is 0 only in these two cases; otherwise it is 1 (including during IDLE, DROP and Reset):
  - (BUSY & Mem_Ack_In & !Id_Stall_In & !Redirect_In)
  - (PEND & !Id_Stall_In & !Redirect_In)
- Consequence: the PC advances exactly at the delivery edge. The PC's own priority lets a redirect override Pause.
- Redirect_In is asserted only after the delay-slot instruction has been delivered. An already-delivered Instr_Out is never flushed by this block.
- Latency and throughput:
  - Minimum 2 cycles per instruction (IDLE 1 cycle + BUSY ≥1 cycle with zero-wait ack).
  - Delivery is visible on Instr_Out the cycle after the ack edge.
- Mem_Addr_Out truncates Pc_In to ADDR_W bits; wrap-around at 2^ADDR_W words is the memory's concern.
- Instr_Pc_Out arithmetic is 32-bit modulo.

Test Plan:
- Reset, then Pc_In=0, zero-wait ack with Rdata=32'h3C01_1234 -> Req at cycle 1; Instr_Out=32'h3C01_1234, Instr_Pc_Out=32'h0000_3000, Valid=1 one cycle after the ack; Pause_Out=0 only in the ack cycle.
- Pc_In=5, ack delayed 3 cycles -> Mem_Addr_Out=5 stable with Req=1 for 3 cycles; Pause_Out=1 throughout; Instr_Pc_Out=32'h0000_3014 on delivery.
- Ack arrives with Id_Stall_In=1 for 2 cycles -> PEND, Pause_Out=1, Instr_Out unchanged; when the stall drops, skid is delivered and Pause_Out=0 in that cycle.
- Redirect_In pulse while BUSY without ack -> DROP; subsequent ack data 32'hDEAD_BEEF never appears on Instr_Out; next request uses the new Pc_In.
- Redirect_In in the same cycle as Ack -> no delivery, IDLE next cycle; Redirect_In in PEND -> skid discarded, Valid stays 0.
- Reset asserted mid-BUSY -> next cycle Req=0, state IDLE, Valid=0, Instr_Pc_Out=32'h0000_3000; a late ack is ignored.
